// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: sequences an iterative AES-128 round datapath, one round per clock
module aes128_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             ld_init,
    output logic             ld_round,
    output logic [3:0]       round_idx,
    output logic [7:0]       rcon,
    output logic             final_round,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
    state_t            state_q, state_d;
    logic [3:0]        round_idx_q, round_idx_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [CNT_W-1:0]  blk_count_q, blk_count_d;
    logic              last_round;
    // state, round index, Rcon and completion counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_idx_q <= 4'd0;
            rcon_q      <= 8'h00;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            rcon_q      <= rcon_d;
            blk_count_q <= blk_count_d;
        end
    end
    // next-state: flush wins over accept and over the output handshake
    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        rcon_d      = rcon_q;
        blk_count_d = blk_count_q;
        if (flush) begin
            state_d     = IDLE;
            round_idx_d = 4'd0;
            rcon_d      = 8'h00;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d     = ROUND;
                    round_idx_d = 4'd1;
                    rcon_d      = 8'h01;
                end
                ROUND: begin
                    rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
                    round_idx_d = last_round ? 4'd0 : round_idx_q + 4'd1;
                    state_d     = last_round ? DONE : ROUND;
                end
                DONE: if (out_ready) begin
                    state_d     = IDLE;
                    blk_count_d = blk_count_q + CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    assign last_round  = (round_idx_q == LAST);
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign ld_init     = (state_q == IDLE) && in_valid && !flush;
    assign ld_round    = (state_q == ROUND) && !flush;
    assign round_idx   = round_idx_q;
    assign rcon        = (state_q == ROUND) ? rcon_q : 8'h00;
    assign final_round = (state_q == ROUND) && last_round;
    assign blk_count   = blk_count_q;
endmodule

// File: tb/tb_aes128_round_ctrl.sv
// tb_aes128_round_ctrl: directed scoreboard bench for the AES-128 round controller
module tb_aes128_round_ctrl;
    localparam int NR = 10;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, out_ready, flush;
    logic          in_ready, out_valid, ld_init, ld_round, final_round, busy;
    logic [3:0]    round_idx;
    logic [7:0]    rcon;
    logic [CW-1:0] blk_count;
    logic [CW-1:0] exp_cnt;
    logic [7:0]    q_rcon[$];
    logic [CW-1:0] q_cnt[$];
    logic [7:0]    rcon_tbl[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    int            n_chk = 0;
    int            n_fail = 0;

    aes128_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .ld_init(ld_init), .ld_round(ld_round), .round_idx(round_idx),
        .rcon(rcon), .final_round(final_round), .busy(busy), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int bp);
        in_valid = 1'b1;
        #1;
        chk("accept_ld_init", 32'(ld_init), 32'd1);
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < NR; k++) q_rcon.push_back(rcon_tbl[k]);
        step();
        for (int i = 1; i <= NR; i++) begin
            in_valid = i[0];
            #1;
            chk("round_ld_round", 32'(ld_round), 32'd1);
            chk("round_idx", 32'(round_idx), 32'(i));
            chk("round_rcon", 32'(rcon), 32'(q_rcon.pop_front()));
            chk("round_final", 32'(final_round), 32'(i == NR));
            chk("round_no_ld_init", 32'(ld_init), 32'd0);
            chk("round_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_round_idx", 32'(round_idx), 32'd0);
        chk("done_rcon", 32'(rcon), 32'd0);
        chk("done_final", 32'(final_round), 32'd0);
        chk("done_ld_round", 32'(ld_round), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        for (int j = 0; j < bp; j++) begin
            in_valid = j[0];
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_ld_init", 32'(ld_init), 32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        q_cnt.push_back(exp_cnt + CW'(1));
        step();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + CW'(1);
        #1;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_blk_count", 32'(blk_count), 32'(q_cnt.pop_front()));
    endtask

    always @(negedge clk) if (reset) chk("ld_exclusive", 32'(ld_init & ld_round), 32'd0);

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        exp_cnt = '0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ld", 32'({ld_init, ld_round}), 32'd0);
        chk("rst_round_idx", 32'(round_idx), 32'd0);
        chk("rst_rcon", 32'(rcon), 32'd0);
        chk("rst_final", 32'(final_round), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_blk_count", 32'(blk_count), 32'd0);
        #4 reset = 1'b1;
        step();
        run_block(0);
        run_block(20);
        in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #1;
        chk("flush_at_round5", 32'(round_idx), 32'd5);
        flush = 1'b1;
        #1;
        chk("flush_ld_round", 32'(ld_round), 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_round_idx", 32'(round_idx), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_rcon", 32'(rcon), 32'd0);
        chk("flush_blk_count", 32'(blk_count), 32'(exp_cnt));
        run_block(0);
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_vs_accept_ld_init", 32'(ld_init), 32'd0);
        step();
        chk("flush_vs_accept_busy", 32'(busy), 32'd0);
        flush = 1'b0;
        #1;
        step();
        in_valid = 1'b0;
        repeat (NR) step();
        chk("pre_flush_done", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        out_ready = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_vs_out_busy", 32'(busy), 32'd0);
        chk("flush_vs_out_count", 32'(blk_count), 32'(exp_cnt));
        in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_ld_round", 32'(ld_round), 32'd0);
        chk("arst_round_idx", 32'(round_idx), 32'd0);
        chk("arst_rcon", 32'(rcon), 32'd0);
        chk("arst_blk_count", 32'(blk_count), 32'd0);
        exp_cnt = '0;
        #1 reset = 1'b1;
        step();
        repeat (17) run_block(0);
        chk("wrap_blk_count", 32'(blk_count), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Sequencing controller for an iterative AES-128 encryption datapath: one round per clock through a shared round unit (SubBytes/ShiftRows/MixColumns/AddRoundKey) and a one-step key-expansion unit.
- Accepts blocks on a valid/ready handshake and generates load enables, round index and Rcon for the datapath.
- Presents completion on a second valid/ready handshake.
- Sits between the block source and the round-datapath registers; holds no 128-bit data itself.

Parameters:
- NUM_ROUNDS, 10, number of full rounds after the initial AddRoundKey (10 for AES-128; legal range 1..15).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  source presents message/key on the datapath inputs.
- in_ready  output  1  controller can accept a block.
- out_valid  output  1  datapath state register holds the ciphertext.
- out_ready  input  1  sink consumes the ciphertext.
- flush  input  1  synchronous abort; returns to IDLE.
- ld_init  output  1  datapath loads state<=message^key, rkey<=key at this edge.
- ld_round  output  1  datapath loads round output and next round key at this edge.
- round_idx  output  4  current round number, 0 outside ROUND.
- rcon  output  8  Rcon byte for the key step in the current round.
- final_round  output  1  current round bypasses MixColumns.
- busy  output  1  block in flight (ROUND or DONE).
- blk_count  output  CNT_W  number of blocks completed (out handshakes).

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=1, out_valid=0, ld_init=0, ld_round=0, round_idx=0, rcon=8'h00, final_round=0, busy=0, blk_count=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1; ld_init=in_valid (combinational).
  - On in_valid=1 at an edge (accept): go to ROUND, round_idx<=1, internal rcon register<=8'h01.
- ROUND:
  - ld_round=1 every cycle; rcon output = rcon register; final_round=(round_idx==NUM_ROUNDS).
  - Each edge: rcon register<=xtime(rcon) (shift left 1; if bit7 was set, XOR 8'h1B); round_idx<=round_idx+1.
  - On the edge with round_idx==NUM_ROUNDS: go to DONE, round_idx<=0.
- Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- DONE:
  - out_valid=1, held stable until out_ready=1; ld_*=0.
  - On out_ready=1: blk_count<=blk_count+1 (wraps at 2^CNT_W-1 -> 0); go to IDLE.
- No back-to-back overlap: in_ready=0 in ROUND and DONE. in_valid there is ignored and never produces ld_init.
- Latency: accept edge E0. ld_round active cycles E0+1..E0+NUM_ROUNDS. out_valid=1 from after edge E0+NUM_ROUNDS. Minimum block period is NUM_ROUNDS+2 cycles with out_ready tied high.
- flush=1 at an edge:
  - Any state -> IDLE; round_idx<=0, rcon register<=0.
  - out_valid drops; blk_count unchanged.
  - flush has priority over accept and over out handshake in the same cycle.
  - While flush=1, ld_init and ld_round are forced 0.
- Outputs outside ROUND: rcon=8'h00, final_round=0.
- Mid-operation reset: immediate return to reset values; the datapath content is don't-care.
- Invariant: ld_init and ld_round never both 1.
- Invariant: busy = (state!=IDLE).

Test Plan:
- Single block, out_ready=1, NUM_ROUNDS=10, accept at cycle 0:
  - ld_round high exactly cycles 1..10 with round_idx 1..10 and rcon 01,02,04,08,10,20,40,80,1B,36.
  - final_round only at round 10.
  - out_valid at cycle 11; blk_count=1 at cycle 12.
- Integrated with round datapath, key 2B7E151628AED2A6ABF7158809CF4F3C, plaintext 3243F6A8885A308D313198A2E0370734 -> ciphertext 3925841D02DC09FBDC118597196A0B32 when out_valid=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid:
  - out_valid stays 1, in_ready stays 0, in_valid pulses produce no ld_init.
  - out_ready=1 -> IDLE next cycle, blk_count+1.
- Flush in round 5 -> next cycle IDLE, round_idx=0, ld_round=0, out_valid never asserted, blk_count unchanged; a new block then completes normally with rcon restarting at 01.
- Async reset low mid-ROUND (between edges) -> all outputs at reset values immediately.
- Counter wrap: CNT_W=4, 17 blocks completed -> blk_count=1.
